// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with wait states and error reporting
// Optional statistics counters are built when DMEM_STATS_EN is defined.
module dmem_responder #(
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        error,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH < 4 || DEPTH > 4096 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be a power of two in 4..4096");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rd_q, wr_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   read_data_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];

  logic          accept, complete, req_err, do_read, do_write;
  logic [AW-1:0] idx;

  // All checks work on the latched request so mid-access input changes are harmless.
  assign req_err  = (addr_q[1:0] != 2'b00) | (addr_q >= ADDR_LIMIT) | (rd_q & wr_q);
  assign idx      = addr_q[AW+1:2];
  assign accept   = (state_q == IDLE) && (mem_read || mem_write);
  assign complete = (state_q == BUSY) && (cnt_q == 4'd0);
  assign do_read  = complete & rd_q & ~req_err;
  assign do_write = complete & wr_q & ~req_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        busy    = 1'b1;
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign error     = ready & err_q;
  assign read_data = read_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rd_q    <= mem_read;
        wr_q    <= mem_write;
        addr_q  <= address;
        wdata_q <= write_data;
      end
      if (complete) begin
        err_q <= req_err;
        if (do_read) read_data_q <= mem_q[idx];
      end
    end
  end

  // Reset has priority, so an access interrupted at its final edge never writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (INIT_ZERO) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
      end
    end else if (do_write) begin
      mem_q[idx] <= wdata_q;
    end
  end

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q  <= 16'd0;
      wr_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else if (complete) begin
      if (req_err) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (rd_q) begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end else begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign rd_count  = 16'd0;
  assign wr_count  = 16'd0;
  assign err_count = 16'd0;
`endif

endmodule
